// File: rtl/m_axis_tx.sv
// m_axis_tx: AXI-Stream master transmitter.
// Buffers words written on data_en/data_in into a circular FIFO and sends
// them out as a frame of frame_len beats, with TLAST on the final beat.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   data_en, data_in      write strobe and word to buffer
//   start, frame_len      frame request and its length (sampled in IDLE)
//   busy, done            frame in progress / one-cycle completion pulse
//   full, overflow        FIFO full / sticky dropped-write flag
//   fifo_count            words currently buffered
//   TVALID, TREADY,
//   TDATA, TLAST          AXI-Stream master channel
module m_axis_tx #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  data_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  output logic                  busy,
  output logic                  done,
  output logic                  full,
  output logic                  overflow,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  TVALID,
  input  logic                  TREADY,
  output logic [DATA_WIDTH-1:0] TDATA,
  output logic                  TLAST
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic [LEN_WIDTH-1:0]  len;
  logic [LEN_WIDTH-1:0]  beat_cnt;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  last_beat;

  // Flags and stream outputs decode registered state only, never TREADY.
  assign full       = (count == (ADDR_WIDTH+1)'(DEPTH));
  assign fifo_count = count;
  assign busy       = (state == STREAM);
  assign done       = (state == DONE);
  assign TVALID     = (state == STREAM) && (count != '0);
  // Head is gated to zero when not valid so idle/reset TDATA reads 0.
  assign TDATA      = TVALID ? mem[rd_ptr] : '0;
  assign last_beat  = (beat_cnt == len - LEN_WIDTH'(1));
  assign TLAST      = TVALID && last_beat;

  assign wr_ok = data_en && !full;
  assign rd_ok = TVALID && TREADY;

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // FIFO pointers, count, overflow flag and frame state machine.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      len      <= '0;
      beat_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_ok) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);

      case ({wr_ok, rd_ok})
        2'b10:   count <= count + (ADDR_WIDTH+1)'(1);
        2'b01:   count <= count - (ADDR_WIDTH+1)'(1);
        default: count <= count;
      endcase

      // A drop in the same cycle as an accepted start still leaves the flag set.
      if (data_en && full) begin
        overflow <= 1'b1;
      end else if (state == IDLE && start && frame_len != '0) begin
        overflow <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start && frame_len != '0) begin
            len      <= frame_len;
            beat_cnt <= '0;
            state    <= STREAM;
          end
        end
        STREAM: begin
          if (rd_ok) begin
            beat_cnt <= beat_cnt + LEN_WIDTH'(1);
            if (last_beat) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
